// File: rtl/q1cau_if.sv
// Control/strobe bundle between the single-qubit butterfly sequencer and its
// amplitude memory / dual complex arithmetic unit.
interface q1cau_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned TW = 4
) ();
  logic          start;
  logic [TW-1:0] target;
  logic          stall;
  logic          cau_overflow;
  logic          busy;
  logic          done;
  logic          err;
  logic          ovf;
  logic          rd_en;
  logic [AW-1:0] rd_addr0;
  logic [AW-1:0] rd_addr1;
  logic          cau_sel;
  logic          cau_sum;
  logic          cau_abs;
  logic          cau_w_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_sel;

  modport master (
    input  start, target, stall, cau_overflow,
    output busy, done, err, ovf, rd_en, rd_addr0, rd_addr1,
    output cau_sel, cau_sum, cau_abs, cau_w_en, wr_en, wr_addr, wr_sel
  );

  modport slave (
    output start, target, stall, cau_overflow,
    input  busy, done, err, ovf, rd_en, rd_addr0, rd_addr1,
    input  cau_sel, cau_sum, cau_abs, cau_w_en, wr_en, wr_addr, wr_sel
  );
endinterface

// File: rtl/q1cau_seq.sv
// Sequencer for one single-qubit butterfly pass over a 2^N_QUBITS state vector:
// per amplitude pair read, sum, difference, then write back i and j.
module q1cau_seq #(
  parameter int unsigned N_QUBITS = 4,
  parameter int unsigned TW       = 4
) (
  input logic      clk,
  input logic      rst_n,
  q1cau_if.master  ctl_io
);
  localparam int unsigned AW = N_QUBITS;
  localparam int unsigned CW = AW - 1;

  typedef enum logic [2:0] {StIdle, StRead, StAdd, StSub, StWrite, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [TW-1:0] t_q, t_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic [AW-1:0] c_ext, lo_mask, idx_i, idx_j;

  // Insert a zero at bit t of the pair counter to form i; j sets that bit.
  always_comb begin
    c_ext   = AW'(c_q);
    lo_mask = (AW'(1) << t_q) - AW'(1);
    idx_i   = (((c_ext >> t_q) << t_q) << 1) | (c_ext & lo_mask);
    idx_j   = idx_i | (AW'(1) << t_q);
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    t_d     = t_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (state_q == StIdle) begin
      if (ctl_io.start) begin
        ovf_d = 1'b0;
        c_d   = '0;
        if (32'(ctl_io.target) >= N_QUBITS) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          err_d   = 1'b0;
          t_d     = ctl_io.target;
          state_d = StRead;
        end
      end
    end else if (!ctl_io.stall) begin
      case (state_q)
        StRead:  state_d = StAdd;
        StAdd: begin
          ovf_d   = ovf_q | ctl_io.cau_overflow;
          state_d = StSub;
        end
        StSub: begin
          ovf_d   = ovf_q | ctl_io.cau_overflow;
          state_d = StWrite;
        end
        StWrite: begin
          if (&c_q) begin
            state_d = StDone;
          end else begin
            c_d     = c_q + CW'(1);
            state_d = StRead;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  logic          busy, done, rd_en, cau_sum, cau_w_en, wr_en, wr_sel;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr;

  // Strobes drop during stall; addresses stay valid since state and c are frozen.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr0 = '0;
    rd_addr1 = '0;
    cau_sum  = 1'b0;
    cau_w_en = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_sel   = 1'b0;
    case (state_q)
      StRead: begin
        busy     = 1'b1;
        rd_en    = !ctl_io.stall;
        rd_addr0 = idx_i;
        rd_addr1 = idx_j;
      end
      StAdd: begin
        busy     = 1'b1;
        cau_sum  = 1'b1;
        cau_w_en = !ctl_io.stall;
      end
      StSub: begin
        busy     = 1'b1;
        cau_w_en = !ctl_io.stall;
        wr_en    = !ctl_io.stall;
        wr_addr  = idx_i;
      end
      StWrite: begin
        busy    = 1'b1;
        wr_en   = !ctl_io.stall;
        wr_addr = idx_j;
        wr_sel  = 1'b1;
      end
      StDone:  done = !ctl_io.stall;
      default: ;
    endcase
  end

  assign ctl_io.busy     = busy;
  assign ctl_io.done     = done;
  assign ctl_io.err      = err_q;
  assign ctl_io.ovf      = ovf_q;
  assign ctl_io.rd_en    = rd_en;
  assign ctl_io.rd_addr0 = rd_addr0;
  assign ctl_io.rd_addr1 = rd_addr1;
  assign ctl_io.cau_sel  = 1'b0;
  assign ctl_io.cau_sum  = cau_sum;
  assign ctl_io.cau_abs  = 1'b0;
  assign ctl_io.cau_w_en = cau_w_en;
  assign ctl_io.wr_en    = wr_en;
  assign ctl_io.wr_addr  = wr_addr;
  assign ctl_io.wr_sel   = wr_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      t_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      t_q     <= t_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_q1cau_seq.sv
// Directed bench for q1cau_seq: pair order, pass length, stall, overflow,
// bad target and mid-pass reset, against hand-computed tables.
module tb_q1cau_seq;
  logic clk;
  logic rst_n;

  q1cau_if #(.AW(4), .TW(4)) bus ();

  q1cau_seq #(.N_QUBITS(4), .TW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rd_log[$];
  logic [4:0] wr_log[$];
  int done_cnt, busy_cnt, cw_cnt, stall_strobes, sel_abs_seen;
  logic ovf_at_done;

  always @(negedge clk) begin
    if (bus.rd_en) rd_log.push_back({bus.rd_addr0, bus.rd_addr1});
    if (bus.wr_en) wr_log.push_back({bus.wr_sel, bus.wr_addr});
    if (bus.done) begin
      done_cnt++;
      ovf_at_done = bus.ovf;
    end
    if (bus.busy) busy_cnt++;
    if (bus.cau_w_en) cw_cnt++;
    if (bus.stall && (bus.rd_en || bus.wr_en || bus.cau_w_en)) stall_strobes++;
    if (bus.cau_sel || bus.cau_abs) sel_abs_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.busy, bus.done, bus.err, bus.ovf, bus.rd_en, bus.rd_addr0, bus.rd_addr1,
                bus.cau_sel, bus.cau_sum, bus.cau_abs, bus.cau_w_en, bus.wr_en, bus.wr_addr,
                bus.wr_sel});
  endfunction

  task automatic clear_logs();
    rd_log.delete();
    wr_log.delete();
    done_cnt      = 0;
    busy_cnt      = 0;
    cw_cnt        = 0;
    stall_strobes = 0;
    sel_abs_seen  = 0;
    ovf_at_done   = 1'b0;
  endtask

  // Leaves the bench at 1 time unit after the accepting edge.
  task automatic do_start(input logic [3:0] tgt);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = tgt;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(negedge clk);
      #1 n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_pass(input string tag, input int ei[8], input int step,
                            input int exp_busy);
    check_eq({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, "_rd_count"}, 32'(rd_log.size()), 32'd8);
    check_eq({tag, "_wr_count"}, 32'(wr_log.size()), 32'd16);
    check_eq({tag, "_cau_w_en_count"}, 32'(cw_cnt), 32'd16);
    check_eq({tag, "_sel_abs_zero"}, 32'(sel_abs_seen), 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k < rd_log.size())
        check_eq($sformatf("%s_rd%0d", tag, k), 32'(rd_log[k]),
                 32'({4'(ei[k]), 4'(ei[k] + step)}));
      if (2 * k + 1 < wr_log.size()) begin
        check_eq($sformatf("%s_wr_i%0d", tag, k), 32'(wr_log[2*k]), 32'({1'b0, 4'(ei[k])}));
        check_eq($sformatf("%s_wr_j%0d", tag, k), 32'(wr_log[2*k+1]),
                 32'({1'b1, 4'(ei[k] + step)}));
      end
    end
  endtask

  int t0_i[8] = '{0, 2, 4, 6, 8, 10, 12, 14};
  int t1_i[8] = '{0, 1, 4, 5, 8, 9, 12, 13};
  int t2_i[8] = '{0, 1, 2, 3, 8, 9, 10, 11};
  int t3_i[8] = '{0, 1, 2, 3, 4, 5, 6, 7};

  initial begin
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.target       = '0;
    bus.stall        = 1'b0;
    bus.cau_overflow = 1'b0;
    clear_logs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;

    // t=0 basic pass
    clear_logs();
    do_start(4'd0);
    wait_done("t0");
    check_pass("t0", t0_i, 1, 32);

    // t=3 with a bad-target start issued mid-pass, which must be ignored
    clear_logs();
    do_start(4'd3);
    repeat (5) @(posedge clk);
    #1 begin bus.start = 1'b1; bus.target = 4'd4; end
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("t3");
    check_pass("t3", t3_i, 8, 32);

    // t=2
    clear_logs();
    do_start(4'd2);
    wait_done("t2");
    check_pass("t2", t2_i, 4, 32);

    // stall for 3 cycles on the first SUB
    clear_logs();
    do_start(4'd0);
    repeat (2) @(posedge clk);
    #1 bus.stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.stall = 1'b0;
    wait_done("stall");
    check_pass("stall", t0_i, 1, 35);
    check_eq("stall_no_strobes", 32'(stall_strobes), 32'd0);

    // bad target
    clear_logs();
    do_start(4'd4);
    @(negedge clk);
    check_eq("bad_done", 32'(bus.done), 32'd1);
    check_eq("bad_err", 32'(bus.err), 32'd1);
    check_eq("bad_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_eq("bad_done_one_pulse", 32'(bus.done), 32'd0);
    check_eq("bad_err_hold", 32'(bus.err), 32'd1);
    repeat (3) @(negedge clk);
    check_eq("bad_no_rd", 32'(rd_log.size()), 32'd0);
    check_eq("bad_no_wr", 32'(wr_log.size()), 32'd0);
    check_eq("bad_done_count", 32'(done_cnt), 32'd1);

    // overflow on ADD of pair 2 (t=1); this start also clears err
    clear_logs();
    do_start(4'd1);
    check_eq("ovf_err_cleared", 32'(bus.err), 32'd0);
    repeat (8) @(posedge clk);
    #1 check_eq("ovf_before", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    #1 bus.cau_overflow = 1'b1;
    @(posedge clk);
    #1 bus.cau_overflow = 1'b0;
    check_eq("ovf_set", 32'(bus.ovf), 32'd1);
    wait_done("ovf");
    check_pass("ovf", t1_i, 2, 32);
    check_eq("ovf_at_done", 32'(ovf_at_done), 32'd1);
    check_eq("ovf_sticky", 32'(bus.ovf), 32'd1);
    clear_logs();
    do_start(4'd0);
    check_eq("ovf_cleared_by_start", 32'(bus.ovf), 32'd0);

    // reset during WRITE of pair 5 of this t=0 pass
    repeat (23) @(posedge clk);
    #1 check_eq("pre_reset_write", 32'({bus.wr_en, bus.wr_sel, bus.wr_addr}), 32'h3b);
    rst_n = 1'b0;
    #1 check_eq("reset_async_outputs", outs(), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("reset_held_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    clear_logs();
    repeat (3) @(negedge clk);
    check_eq("post_reset_idle", 32'(rd_log.size() + wr_log.size() + busy_cnt), 32'd0);
    do_start(4'd0);
    wait_done("restart");
    check_pass("restart", t0_i, 1, 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
